// File: rtl/matmul_job_sched.sv
// Job scheduler for a single matmul engine: buffers descriptors in a FIFO, launches
// them one at a time and reports each completion with its tag and cycle count.
module matmul_job_sched #(
  parameter int          DIM_BITS = 16,
  parameter int          MEM_AW   = 16,
  parameter int          DEPTH    = 4,
  parameter int          TAG_W    = 4,
  parameter int          CNT_W    = 24,
  parameter logic [3:0]  ENG_IDLE = 4'd1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       job_valid,
  output logic                       job_ready,
  input  logic [MEM_AW-1:0]          job_a_base,
  input  logic [MEM_AW-1:0]          job_b_base,
  input  logic [MEM_AW-1:0]          job_c_base,
  input  logic [DIM_BITS-1:0]        job_a_rows,
  input  logic [DIM_BITS-1:0]        job_a_cols,
  input  logic [DIM_BITS-1:0]        job_b_cols,
  input  logic [DIM_BITS-1:0]        job_a_stride,
  input  logic [DIM_BITS-1:0]        job_b_stride,
  input  logic [DIM_BITS-1:0]        job_c_stride,
  input  logic [TAG_W-1:0]           job_tag,
  output logic [MEM_AW-1:0]          eng_aBASE,
  output logic [MEM_AW-1:0]          eng_bBASE,
  output logic [MEM_AW-1:0]          eng_cBASE,
  output logic [DIM_BITS-1:0]        eng_aROWS,
  output logic [DIM_BITS-1:0]        eng_aCOLS,
  output logic [DIM_BITS-1:0]        eng_bCOLS,
  output logic [DIM_BITS-1:0]        eng_aSTRIDE,
  output logic [DIM_BITS-1:0]        eng_bSTRIDE,
  output logic [DIM_BITS-1:0]        eng_cSTRIDE,
  output logic                       eng_go,
  input  logic                       eng_ret,
  input  logic [3:0]                 eng_state,
  output logic                       done_valid,
  output logic [TAG_W-1:0]           done_tag,
  output logic [CNT_W-1:0]           done_cycles,
  output logic [15:0]                jobs_done,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [MEM_AW-1:0]   a_base;
    logic [MEM_AW-1:0]   b_base;
    logic [MEM_AW-1:0]   c_base;
    logic [DIM_BITS-1:0] a_rows;
    logic [DIM_BITS-1:0] a_cols;
    logic [DIM_BITS-1:0] b_cols;
    logic [DIM_BITS-1:0] a_stride;
    logic [DIM_BITS-1:0] b_stride;
    logic [DIM_BITS-1:0] c_stride;
    logic [TAG_W-1:0]    tag;
  } job_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2
  } state_t;

  job_t             fifo_mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [TAG_W-1:0] run_tag_r;
  logic             ret_q_r;
  job_t             head_s;
  job_t             in_job_s;
  logic             push_s;
  logic             pop_s;
  logic             launch_s;
  logic             zero_done_s;
  logic             run_done_s;
  logic             head_zero_s;
  logic             ret_rise_s;
  logic             fifo_empty_s;
  logic [CW-1:0]    count_nxt_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (v == {CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + CNT_W'(1'b1);
    end
  endfunction

  assign in_job_s = {job_a_base, job_b_base, job_c_base, job_a_rows, job_a_cols,
                     job_b_cols, job_a_stride, job_b_stride, job_c_stride, job_tag};
  assign head_s       = fifo_mem_r[rd_ptr_r];
  assign fifo_empty_s = (fifo_count == {CW{1'b0}});
  assign push_s       = job_valid && job_ready;
  // A job with no output rows or columns never touches the engine.
  assign head_zero_s  = (head_s.a_rows == {DIM_BITS{1'b0}}) || (head_s.b_cols == {DIM_BITS{1'b0}});
  assign ret_rise_s   = eng_ret && !ret_q_r;
  assign cnt_inc_s    = sat_inc(cnt_r);

  // Scheduler state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (!fifo_empty_s && !head_zero_s && (eng_state == ENG_IDLE)) begin
          state_nxt_s = S_LAUNCH;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_LAUNCH: state_nxt_s = S_RUN;
      S_RUN: begin
        if (ret_rise_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_RUN;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Per-state action strobes
  always_comb begin
    zero_done_s = 1'b0;
    launch_s    = 1'b0;
    run_done_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        zero_done_s = !fifo_empty_s && head_zero_s;
        launch_s    = !fifo_empty_s && !head_zero_s && (eng_state == ENG_IDLE);
      end
      S_RUN:   run_done_s = ret_rise_s;
      default: run_done_s = 1'b0;
    endcase
    pop_s = zero_done_s || launch_s;
  end

  // Occupancy after this cycle's push/pop
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = fifo_count + CW'(1'b1);
      2'b01:   count_nxt_s = fifo_count - CW'(1'b1);
      default: count_nxt_s = fifo_count;
    endcase
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= in_job_s;
    end
  end

  // FIFO pointers and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      fifo_count <= {CW{1'b0}};
      job_ready  <= 1'b1;
      busy       <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      fifo_count <= count_nxt_s;
      job_ready  <= (count_nxt_s != CW'(DEPTH));
      busy       <= (state_nxt_s != S_IDLE) || (count_nxt_s != {CW{1'b0}});
    end
  end

  // Engine launch, cycle counter and completion reporting
  always_ff @(posedge clk) begin
    if (rst) begin
      ret_q_r     <= 1'b1;
      eng_go      <= 1'b0;
      eng_aBASE   <= {MEM_AW{1'b0}};
      eng_bBASE   <= {MEM_AW{1'b0}};
      eng_cBASE   <= {MEM_AW{1'b0}};
      eng_aROWS   <= {DIM_BITS{1'b0}};
      eng_aCOLS   <= {DIM_BITS{1'b0}};
      eng_bCOLS   <= {DIM_BITS{1'b0}};
      eng_aSTRIDE <= {DIM_BITS{1'b0}};
      eng_bSTRIDE <= {DIM_BITS{1'b0}};
      eng_cSTRIDE <= {DIM_BITS{1'b0}};
      run_tag_r   <= {TAG_W{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      done_valid  <= 1'b0;
      done_tag    <= {TAG_W{1'b0}};
      done_cycles <= {CNT_W{1'b0}};
      jobs_done   <= 16'd0;
    end else begin
      ret_q_r <= eng_ret;
      eng_go  <= launch_s;
      if (launch_s) begin
        eng_aBASE   <= head_s.a_base;
        eng_bBASE   <= head_s.b_base;
        eng_cBASE   <= head_s.c_base;
        eng_aROWS   <= head_s.a_rows;
        eng_aCOLS   <= head_s.a_cols;
        eng_bCOLS   <= head_s.b_cols;
        eng_aSTRIDE <= head_s.a_stride;
        eng_bSTRIDE <= head_s.b_stride;
        eng_cSTRIDE <= head_s.c_stride;
        run_tag_r   <= head_s.tag;
      end
      // Counter is 0 at launch, 1 after the go cycle, so the reported count
      // is the number of edges from go assertion to the sampled ret rise.
      if (launch_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (state_r != S_IDLE) begin
        cnt_r <= cnt_inc_s;
      end
      done_valid <= zero_done_s || run_done_s;
      if (zero_done_s) begin
        done_tag    <= head_s.tag;
        done_cycles <= {CNT_W{1'b0}};
      end else if (run_done_s) begin
        done_tag    <= run_tag_r;
        done_cycles <= cnt_inc_s;
      end
      if (zero_done_s || run_done_s) begin
        jobs_done <= jobs_done + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_matmul_job_sched.sv
// Directed bench for matmul_job_sched: a behavioural engine answers eng_go, expected
// completions are queued at push time and a monitor checks every done_valid pulse.
module tb_matmul_job_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        job_valid;
  logic        job_ready;
  logic [15:0] job_a_base, job_b_base, job_c_base;
  logic [15:0] job_a_rows, job_a_cols, job_b_cols;
  logic [15:0] job_a_stride, job_b_stride, job_c_stride;
  logic [3:0]  job_tag;
  logic [15:0] eng_aBASE, eng_bBASE, eng_cBASE;
  logic [15:0] eng_aROWS, eng_aCOLS, eng_bCOLS;
  logic [15:0] eng_aSTRIDE, eng_bSTRIDE, eng_cSTRIDE;
  logic        eng_go;
  logic        eng_ret;
  logic [3:0]  eng_state;
  logic        done_valid;
  logic [3:0]  done_tag;
  logic [3:0]  done_cycles;
  logic [15:0] jobs_done;
  logic [2:0]  fifo_count;
  logic        busy;

  logic [3:0]  eng_state_m;
  logic        eng_force_en;
  logic [3:0]  eng_force_val;
  int          eng_delay;
  int          ret_len;

  int checks   = 0;
  int failures = 0;
  int exp_tag_q[$];
  int exp_cyc_q[$];
  int mon_tag, mon_cyc;

  assign eng_state = eng_force_en ? eng_force_val : eng_state_m;

  matmul_job_sched #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready),
    .job_a_base(job_a_base), .job_b_base(job_b_base), .job_c_base(job_c_base),
    .job_a_rows(job_a_rows), .job_a_cols(job_a_cols), .job_b_cols(job_b_cols),
    .job_a_stride(job_a_stride), .job_b_stride(job_b_stride), .job_c_stride(job_c_stride),
    .job_tag(job_tag),
    .eng_aBASE(eng_aBASE), .eng_bBASE(eng_bBASE), .eng_cBASE(eng_cBASE),
    .eng_aROWS(eng_aROWS), .eng_aCOLS(eng_aCOLS), .eng_bCOLS(eng_bCOLS),
    .eng_aSTRIDE(eng_aSTRIDE), .eng_bSTRIDE(eng_bSTRIDE), .eng_cSTRIDE(eng_cSTRIDE),
    .eng_go(eng_go), .eng_ret(eng_ret), .eng_state(eng_state),
    .done_valid(done_valid), .done_tag(done_tag), .done_cycles(done_cycles),
    .jobs_done(jobs_done), .fifo_count(fifo_count), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Engine model: ret rises eng_delay negedges after go is seen, so the
  // expected cycle count is eng_delay+1.
  initial begin
    eng_state_m = 4'd1;
    eng_ret     = 1'b0;
    forever begin
      @(negedge clk);
      if (eng_go) begin
        eng_state_m = 4'd3;
        repeat (eng_delay) @(negedge clk);
        eng_ret = 1'b1;
        repeat (ret_len) @(negedge clk);
        eng_ret = 1'b0;
        @(negedge clk);
        eng_state_m = 4'd1;
      end
    end
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (done_valid) begin
      if (exp_tag_q.size() == 0) begin
        check("unexpected_done", done_valid, 1'b0);
      end else begin
        mon_tag = exp_tag_q.pop_front();
        mon_cyc = exp_cyc_q.pop_front();
        check("done_tag", done_tag, mon_tag);
        check("done_cycles", done_cycles, mon_cyc);
      end
    end
  end

  // Called at a negedge; returns at the negedge right after the push edge.
  task automatic push_job(input logic [3:0] tag, input int exp_cyc);
    int n = 0;
    job_tag   = tag;
    job_valid = 1'b1;
    while (!job_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!job_ready) begin
      check("push_ready_timeout", job_ready, 1'b1);
      job_valid = 1'b0;
    end else begin
      exp_tag_q.push_back(tag);
      exp_cyc_q.push_back(exp_cyc);
      @(negedge clk);
      job_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_tag_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("drain_complete", exp_tag_q.size(), 0);
    repeat (8) @(negedge clk);
  endtask

  task automatic set_fields(input logic [15:0] ab, input logic [15:0] bb, input logic [15:0] cb,
                            input logic [15:0] r, input logic [15:0] c, input logic [15:0] bc,
                            input logic [15:0] sa, input logic [15:0] sb, input logic [15:0] sc);
    job_a_base = ab; job_b_base = bb; job_c_base = cb;
    job_a_rows = r;  job_a_cols = c;  job_b_cols = bc;
    job_a_stride = sa; job_b_stride = sb; job_c_stride = sc;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic seen_go, seen_dv;
    rst = 1'b1;
    job_valid = 1'b0;
    job_tag = 4'd0;
    eng_force_en = 1'b0;
    eng_force_val = 4'd0;
    eng_delay = 3;
    ret_len = 2;
    set_fields(16'h0, 16'h0, 16'h0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    repeat (3) @(negedge clk);

    check("rst_job_ready", job_ready, 1'b1);
    check("rst_eng_go", eng_go, 1'b0);
    check("rst_done_valid", done_valid, 1'b0);
    check("rst_fifo_count", fifo_count, 3'd0);
    check("rst_busy", busy, 1'b0);
    check("rst_jobs_done", jobs_done, 16'd0);
    check("rst_eng_bBASE", eng_bBASE, 16'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single 2x2 job, tag 5, ret 4 negedges after go -> 5 cycles
    eng_delay = 4;
    set_fields(16'h000, 16'h100, 16'h200, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2);
    push_job(4'd5, 5);
    check("single_go_t1", eng_go, 1'b0);
    check("single_count_t1", fifo_count, 3'd1);
    check("single_busy", busy, 1'b1);
    @(negedge clk);
    check("single_go_t2", eng_go, 1'b1);
    check("single_count_t2", fifo_count, 3'd0);
    check("single_aBASE", eng_aBASE, 16'h000);
    check("single_bBASE", eng_bBASE, 16'h100);
    check("single_cBASE", eng_cBASE, 16'h200);
    check("single_aROWS", eng_aROWS, 16'd2);
    check("single_aCOLS", eng_aCOLS, 16'd2);
    check("single_bCOLS", eng_bCOLS, 16'd2);
    check("single_aSTRIDE", eng_aSTRIDE, 16'd2);
    check("single_bSTRIDE", eng_bSTRIDE, 16'd2);
    check("single_cSTRIDE", eng_cSTRIDE, 16'd2);
    @(negedge clk);
    check("single_go_t3", eng_go, 1'b0);
    drain();
    check("single_jobs_done", jobs_done, 16'd1);
    check("single_cBASE_hold", eng_cBASE, 16'h200);

    // Zero jobs with engine not idle: never launched, zero cycles
    eng_force_en = 1'b1;
    eng_force_val = 4'd5;
    set_fields(16'h010, 16'h020, 16'h030, 16'd0, 16'd2, 16'd2, 16'd1, 16'd1, 16'd1);
    push_job(4'd9, 0);
    check("zero_dv_t1", done_valid, 1'b0);
    @(negedge clk);
    check("zero_dv_t2", done_valid, 1'b1);
    check("zero_go", eng_go, 1'b0);
    check("zero_count", fifo_count, 3'd0);
    job_a_rows = 16'd3;
    job_b_cols = 16'd0;
    push_job(4'd10, 0);
    seen_go = 1'b0;
    for (int i = 0; i < 4; i++) begin
      seen_go = seen_go | eng_go;
      @(negedge clk);
    end
    check("zero_no_go", seen_go, 1'b0);
    drain();
    check("zero_jobs_done", jobs_done, 16'd3);

    // Engine never idle, then released
    eng_delay = 3;
    eng_force_val = 4'd4;
    set_fields(16'h1234, 16'h2345, 16'h3456, 16'd3, 16'd5, 16'd7, 16'd11, 16'd13, 16'd17);
    push_job(4'd7, 4);
    seen_go = 1'b0;
    for (int i = 0; i < 6; i++) begin
      seen_go = seen_go | eng_go;
      @(negedge clk);
    end
    check("stuck_no_go", seen_go, 1'b0);
    check("stuck_busy", busy, 1'b1);
    check("stuck_count", fifo_count, 3'd1);
    eng_force_en = 1'b0;
    @(negedge clk);
    check("release_go", eng_go, 1'b1);
    check("release_aBASE", eng_aBASE, 16'h1234);
    check("release_bBASE", eng_bBASE, 16'h2345);
    check("release_cBASE", eng_cBASE, 16'h3456);
    check("release_aROWS", eng_aROWS, 16'd3);
    check("release_aCOLS", eng_aCOLS, 16'd5);
    check("release_bCOLS", eng_bCOLS, 16'd7);
    check("release_aSTRIDE", eng_aSTRIDE, 16'd11);
    check("release_bSTRIDE", eng_bSTRIDE, 16'd13);
    check("release_cSTRIDE", eng_cSTRIDE, 16'd17);
    drain();
    check("stuck_jobs_done", jobs_done, 16'd4);

    // Fill the FIFO while the engine is busy
    eng_force_en = 1'b1;
    eng_force_val = 4'd3;
    set_fields(16'h040, 16'h050, 16'h060, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2, 16'd2);
    for (int i = 0; i < 4; i++) begin
      push_job(i[3:0], 4);
    end
    check("fill_ready_low", job_ready, 1'b0);
    check("fill_count4", fifo_count, 3'd4);
    check("fill_no_go", eng_go, 1'b0);
    job_tag = 4'd4;
    job_valid = 1'b1;
    exp_tag_q.push_back(4);
    exp_cyc_q.push_back(4);
    eng_force_en = 1'b0;
    @(negedge clk);
    check("fill_pop_go", eng_go, 1'b1);
    check("fill_ready_back", job_ready, 1'b1);
    check("fill_count3", fifo_count, 3'd3);
    @(negedge clk);
    check("fill_fifth_accepted", fifo_count, 3'd4);
    job_valid = 1'b0;
    drain();
    check("fill_jobs_done", jobs_done, 16'd9);

    // Saturating cycle counter with a long ret pulse
    eng_delay = 30;
    ret_len = 4;
    push_job(4'd6, 15);
    drain();
    check("sat_jobs_done", jobs_done, 16'd10);
    ret_len = 2;

    // Reset while the engine is running
    eng_delay = 12;
    push_job(4'd3, 13);
    for (int i = 0; i < 20 && !eng_go; i++) @(negedge clk);
    check("rr_launch_seen", eng_go, 1'b1);
    repeat (3) @(negedge clk);
    push_job(4'd2, 4);
    check("rr_count_before", fifo_count, 3'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_tag_q.delete();
    exp_cyc_q.delete();
    check("rr_eng_go", eng_go, 1'b0);
    check("rr_done_valid", done_valid, 1'b0);
    check("rr_jobs_done", jobs_done, 16'd0);
    check("rr_fifo_count", fifo_count, 3'd0);
    check("rr_busy", busy, 1'b0);
    check("rr_job_ready", job_ready, 1'b1);
    check("rr_aBASE", eng_aBASE, 16'd0);
    check("rr_cSTRIDE", eng_cSTRIDE, 16'd0);
    check("rr_done_tag", done_tag, 4'd0);
    seen_go = 1'b0;
    seen_dv = 1'b0;
    for (int i = 0; i < 25; i++) begin
      seen_go = seen_go | eng_go;
      seen_dv = seen_dv | done_valid;
      @(negedge clk);
    end
    check("rr_no_done_after_ret", seen_dv, 1'b0);
    check("rr_no_relaunch", seen_go, 1'b0);
    check("rr_jobs_done_after", jobs_done, 16'd0);
    check("rr_busy_after", busy, 1'b0);

    check("final_queue_empty", exp_tag_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
